// File: rtl/avalon_mem_unit.sv
// Shared Avalon-MM master for the multicycle MIPS core: arbitrates fetch and data requests,
// runs one bus transaction at a time and performs store lane steering and load extraction.
module avalon_mem_unit #(
  parameter int unsigned TIMEOUT       = 0,
  parameter bit          DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [1:0]  d_lr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_merge,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        gnt_data_q, gnt_data_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lr_q, lr_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] merge_q, merge_d;

  logic        pick_data;
  logic        misaligned;
  logic [31:0] load_result;
  logic [31:0] shifted;
  logic [4:0]  sh_right;
  logic [4:0]  sh_left;

  // Load extraction from the raw bus word using the latched command.
  always_comb begin
    sh_right    = {off_q, 3'b000};
    sh_left     = {~off_q, 3'b000};
    shifted     = readdata >> sh_right;
    load_result = readdata;
    unique case (lr_q)
      2'b01: load_result = (readdata << sh_left) | (merge_q & ((32'h1 << sh_left) - 32'h1));
      2'b10: load_result = shifted | (merge_q & ~(32'hFFFF_FFFF >> sh_right));
      default: begin
        unique case (size_q)
          2'b00: load_result = {{24{signed_q & shifted[7]}}, shifted[7:0]};
          2'b01: load_result = {{16{signed_q & shifted[15]}}, shifted[15:0]};
          default: load_result = readdata;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    addr_d     = addr_q;
    read_d     = read_q;
    write_d    = write_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    size_d     = size_q;
    signed_d   = signed_q;
    lr_d       = lr_q;
    off_d      = off_q;
    merge_d    = merge_q;
    pick_data  = d_req && (DATA_PRIORITY || !i_req);
    misaligned = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          gnt_data_d = pick_data;
          cnt_d      = '0;
          rdata_d    = '0;
          err_d      = 1'b0;
          if (pick_data) begin
            addr_d   = {d_addr[31:2], 2'b00};
            off_d    = d_addr[1:0];
            size_d   = d_size;
            signed_d = d_signed;
            lr_d     = d_lr;
            merge_d  = d_merge;
            read_d   = !d_we;
            write_d  = d_we;
            misaligned = (d_lr == 2'b00) &&
                         (((d_size == 2'b01) && d_addr[0]) ||
                          (d_size[1] && (d_addr[1:0] != 2'b00)));
            unique case (d_size)
              2'b00:   wdata_d = {4{d_wdata[7:0]}};
              2'b01:   wdata_d = {2{d_wdata[15:0]}};
              default: wdata_d = d_wdata;
            endcase
            if (d_lr != 2'b00) begin
              be_d = 4'b1111;
            end else begin
              unique case (d_size)
                2'b00:   be_d = 4'b0001 << d_addr[1:0];
                2'b01:   be_d = d_addr[1] ? 4'b1100 : 4'b0011;
                default: be_d = 4'b1111;
              endcase
            end
          end else begin
            addr_d     = {i_addr[31:2], 2'b00};
            read_d     = 1'b1;
            write_d    = 1'b0;
            be_d       = 4'b1111;
            wdata_d    = '0;
            misaligned = (i_addr[1:0] != 2'b00);
          end
          if (misaligned) begin
            // No bus cycle at all: answer with an error straight away.
            read_d  = 1'b0;
            write_d = 1'b0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (!gnt_data_q)  rdata_d = readdata;
          else if (write_q) rdata_d = '0;
          else              rdata_d = load_result;
          state_d = StResp;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == TIMEOUT - 1) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      lr_q       <= '0;
      off_q      <= '0;
      merge_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      lr_q       <= lr_d;
      off_q      <= off_d;
      merge_q    <= merge_d;
    end
  end

  always_comb begin
    i_ack      = (state_q == StResp) && !gnt_data_q;
    d_ack      = (state_q == StResp) && gnt_data_q;
    i_rdata    = i_ack ? rdata_q : '0;
    d_rdata    = d_ack ? rdata_q : '0;
    i_err      = i_ack && err_q;
    d_err      = d_ack && err_q;
    address    = addr_q;
    read       = read_q;
    write      = write_q;
    byteenable = be_q;
    writedata  = wdata_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_avalon_mem_unit.sv
// Directed and randomized bench for avalon_mem_unit against a byte-level reference model.
module tb_avalon_mem_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [1:0]  d_lr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_merge;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  avalon_mem_unit #(.TIMEOUT(TO), .DATA_PRIORITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_lr(d_lr),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_merge(d_merge),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load result, built byte by byte from the little-endian lane rules.
  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sgn,
                                           input logic [1:0] lr, input int off,
                                           input logic [31:0] mem, input logic [31:0] merge);
    logic [7:0]  b [4];
    logic [7:0]  m [4];
    logic [7:0]  r [4];
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      b[k] = mem[8*k +: 8];
      m[k] = merge[8*k +: 8];
    end
    if (lr == 2'b01) begin
      for (int i = 0; i < 4; i++) r[i] = (i >= 3 - off) ? b[i - (3 - off)] : m[i];
      return {r[3], r[2], r[1], r[0]};
    end
    if (lr == 2'b10) begin
      for (int i = 0; i < 4; i++) r[i] = (i + off <= 3) ? b[i + off] : m[i];
      return {r[3], r[2], r[1], r[0]};
    end
    if (size == 2'b00) begin
      v = {24'h0, b[off]};
      if (sgn && b[off][7]) v = v - 32'h100;
      return v;
    end
    if (size == 2'b01) begin
      v = {16'h0, b[off + 1], b[off]};
      if (sgn && b[off + 1][7]) v = v - 32'h10000;
      return v;
    end
    return mem;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] lr,
                                        input int off);
    if (lr != 2'b00 || size >= 2) return 4'hF;
    if (size == 2'b00) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (size == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  // One complete transaction on one port, starting and ending in an idle cycle.
  task automatic do_txn(input bit is_data, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [1:0] lr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] merge, input int nwait, input bit fix,
                        input logic [31:0] memv, input bit use_exp, input logic [31:0] exp_rd);
    int          off;
    bit          mis;
    bit          is_wr;
    bit          stall;
    bit          tout;
    int          stalls;
    logic [31:0] mem;
    logic [31:0] want;
    logic [31:0] got_rd;
    off    = int'(addr[1:0]);
    is_wr  = is_data && we && (lr == 2'b00);
    stalls = 0;
    tout   = 1'b0;
    mem    = 32'h0;
    if (is_data) mis = (lr == 2'b00) && ((size == 2'b01 && off % 2 == 1) || (size >= 2 && off != 0));
    else         mis = (off != 0);
    if (is_data) begin
      d_we = is_wr; d_size = size; d_signed = sgn; d_lr = lr; d_addr = addr;
      d_wdata = wdata; d_merge = merge; d_req = 1'b1; i_addr = $urandom;
    end else begin
      d_we = $urandom; d_size = 2'($urandom); d_signed = $urandom; d_lr = 2'($urandom);
      d_addr = $urandom; d_wdata = $urandom; d_merge = $urandom;
      i_addr = addr; i_req = 1'b1;
    end
    waitrequest = (nwait > 0);
    readdata    = $urandom;
    @(posedge clk); #1;
    if (mis) begin
      chk("mis_strobes", {30'h0, read, write}, 32'h0);
    end else begin
      chk("strobes", {30'h0, read, write}, {30'h0, !is_wr, is_wr});
      chk("address", address, {addr[31:2], 2'b00});
      chk("byteenable", {28'h0, byteenable}, {28'h0, is_data ? ref_be(size, lr, off) : 4'hF});
      if (is_wr) chk("writedata", writedata, ref_wd(size, wdata));
      for (int c = 0; c < 64; c++) begin
        mem         = fix ? memv : $urandom;
        readdata    = mem;
        stall       = (stalls < nwait);
        waitrequest = stall;
        @(posedge clk); #1;
        if (!stall) break;
        stalls++;
        if (stalls == TO) begin
          tout = 1'b1;
          break;
        end
        chk("stall_strobes", {30'h0, read, write}, {30'h0, !is_wr, is_wr});
        chk("stall_address", address, {addr[31:2], 2'b00});
        chk("stall_ack", {30'h0, i_ack, d_ack}, 32'h0);
      end
      chk("resp_strobes", {30'h0, read, write}, 32'h0);
    end
    if (mis || tout)     want = 32'h0;
    else if (use_exp)    want = exp_rd;
    else if (is_data)    want = ref_load(size, sgn, lr, off, mem, merge);
    else                 want = mem;
    chk("ack", {30'h0, i_ack, d_ack}, {30'h0, !is_data, is_data});
    chk("err", {31'h0, is_data ? d_err : i_err}, {31'h0, mis || tout});
    got_rd = is_data ? d_rdata : i_rdata;
    if (!is_wr || mis || tout) chk("rdata", got_rd, want);
    chk("other_rdata", is_data ? i_rdata : d_rdata, 32'h0);
    i_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    @(posedge clk); #1;
    chk("idle_ack", {30'h0, i_ack, d_ack}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
    d_signed = 1'b0; d_lr = '0; d_addr = '0; d_wdata = '0; d_merge = '0;
    waitrequest = 1'b0; readdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_strobes", {30'h0, read, write}, 32'h0);
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_be", {28'h0, byteenable}, 32'h0);
    chk("rst_outs", {28'h0, busy, i_ack, d_ack, i_err | d_err}, 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);
    reset = 1'b0;

    // Fetch, zero wait.
    do_txn(0, 0, 2'd2, 0, 2'd0, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    // Store byte to lane 3.
    do_txn(1, 1, 2'd0, 0, 2'd0, 32'h203, 32'h0000_00A5, 0, 0, 0, 0, 0, 0);
    // Loads against a fixed word.
    do_txn(1, 0, 2'd1, 1, 2'd0, 32'h202, 0, 0, 0, 1, 32'h80FF1234, 1, 32'hFFFF80FF);
    do_txn(1, 0, 2'd1, 0, 2'd0, 32'h202, 0, 0, 1, 1, 32'h80FF1234, 1, 32'h000080FF);
    do_txn(1, 0, 2'd0, 1, 2'd0, 32'h203, 0, 0, 2, 1, 32'h80FF1234, 1, 32'hFFFFFF80);
    do_txn(1, 0, 2'd2, 0, 2'd1, 32'h202, 0, 32'h11223344, 0, 1, 32'h80FF1234, 1, 32'hFF123444);
    do_txn(1, 0, 2'd2, 0, 2'd2, 32'h202, 0, 32'h11223344, 0, 1, 32'h80FF1234, 1, 32'h112280FF);
    // Misaligned word load, then a stuck bus.
    do_txn(1, 0, 2'd2, 0, 2'd0, 32'h201, 0, 0, 0, 0, 0, 0, 0);
    do_txn(1, 0, 2'd2, 0, 2'd0, 32'h204, 0, 0, 1000, 0, 0, 0, 0);

    // Simultaneous requests: data first, then fetch after one idle cycle.
    i_addr = 32'h100; i_req = 1'b1;
    d_addr = 32'h300; d_we = 1'b0; d_size = 2'd2; d_lr = 2'd0; d_signed = 1'b0; d_req = 1'b1;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    chk("both_first_addr", address, 32'h300);
    chk("both_first_read", {31'h0, read}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      readdata = $urandom; waitrequest = 1'b1;
      @(posedge clk); #1;
      chk("both_stall", {29'h0, read, i_ack, d_ack}, 32'h4);
    end
    waitrequest = 1'b0; readdata = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("both_dack", {29'h0, read, i_ack, d_ack}, 32'h1);
    chk("both_drdata", d_rdata, 32'h0BADF00D);
    d_req = 1'b0; readdata = $urandom;
    @(posedge clk); #1;
    chk("both_gap", {28'h0, busy, read, i_ack, d_ack}, 32'h0);
    @(posedge clk); #1;
    chk("both_fetch_addr", address, 32'h100);
    chk("both_fetch_read", {31'h0, read}, 32'h1);
    readdata = 32'h12345678;
    @(posedge clk); #1;
    chk("both_iack", {29'h0, read, i_ack, d_ack}, 32'h2);
    chk("both_irdata", i_rdata, 32'h12345678);
    i_req = 1'b0;
    @(posedge clk); #1;
    chk("both_end", {29'h0, busy, i_ack, d_ack}, 32'h0);

    // Reset while a store is stalled on the bus.
    d_addr = 32'h400; d_we = 1'b1; d_size = 2'd2; d_lr = 2'd0; d_wdata = 32'hCAFEF00D;
    d_req = 1'b1; waitrequest = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_write", {31'h0, write}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_strobes", {29'h0, busy, read, write}, 32'h0);
    chk("rst_acc_ack", {30'h0, i_ack, d_ack}, 32'h0);
    reset = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
    @(posedge clk); #1;
    chk("rst_acc_noack", {29'h0, busy, i_ack, d_ack}, 32'h0);

    // Randomized mix, including occasional timeouts and misalignment.
    for (int n = 0; n < 60; n++) begin
      bit          isd;
      logic [1:0]  lr;
      logic [1:0]  sz;
      logic [31:0] a;
      isd = ($urandom % 4) != 0;
      lr  = 2'b00;
      if (isd && ($urandom % 3) == 0) lr = ($urandom % 2) ? 2'b01 : 2'b10;
      sz  = 2'($urandom_range(0, 2));
      a   = $urandom;
      if (!isd && ($urandom % 8) != 0) a[1:0] = 2'b00;
      do_txn(isd, $urandom, sz, $urandom, lr, a, $urandom, $urandom, $urandom_range(0, 5),
             0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
